// File: rtl/end_game_if.sv
// Handshake bundle between the game core / keypad and the end-game sequencer.
interface end_game_if #(
   parameter int SCORE_W = 16
);
   logic               startOfFrame;
   logic               playerDead;
   logic               invadersLanded;
   logic [SCORE_W-1:0] score;
   logic               keyStart;
   logic               keyCredit;
   logic               gameEnded;
   logic               newHighScore;
   logic [SCORE_W-1:0] highScore;
   logic               creditsActive;
   logic               restartGame;

   modport master (
      output startOfFrame, playerDead, invadersLanded, score,
      output keyStart, keyCredit,
      input  gameEnded, newHighScore, highScore, creditsActive, restartGame
   );

   modport slave (
      input  startOfFrame, playerDead, invadersLanded, score,
      input  keyStart, keyCredit,
      output gameEnded, newHighScore, highScore, creditsActive, restartGame
   );
endinterface

// File: rtl/end_game_ctrl.sv
// Game-end sequencer: death pause, end screen, credits view, high score
// tracking and restart pulse back to the game core.
module end_game_ctrl #(
   parameter int SCORE_W            = 16,
   parameter int DEATH_DELAY_FRAMES = 60,
   parameter int MIN_END_FRAMES     = 30,
   parameter int CREDIT_FRAMES      = 300
) (
   input logic       clk,
   input logic       reset,
   end_game_if.slave bus
);
   typedef enum logic [1:0] {PLAY, DYING, OVER, CREDITS} state_e;

   localparam logic [8:0] DEATH_N = 9'(DEATH_DELAY_FRAMES);
   localparam logic [8:0] MIN_N   = 9'(MIN_END_FRAMES);
   localparam logic [8:0] CRED_N  = 9'(CREDIT_FRAMES);

   state_e             state_q, state_d;
   logic [8:0]         cnt_q, cnt_d;
   logic [SCORE_W-1:0] final_q, final_d;
   logic [SCORE_W-1:0] high_q, high_d;
   logic               ended_q, ended_d;
   logic               nhs_q, nhs_d;
   logic               cred_q, cred_d;
   logic               rst_g_q, rst_g_d;
   logic [8:0]         cnt_inc;
   logic               keys_ok;

   assign cnt_inc = cnt_q + 9'd1;
   assign keys_ok = (cnt_q == MIN_N);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      final_d = final_q;
      high_d  = high_q;
      ended_d = ended_q;
      nhs_d   = nhs_q;
      cred_d  = cred_q;
      rst_g_d = 1'b0;
      unique case (state_q)
         PLAY: begin
            if (bus.playerDead | bus.invadersLanded) begin
               final_d = bus.score;
               cnt_d   = '0;
               state_d = DYING;
            end
         end
         DYING: begin
            if (bus.startOfFrame) begin
               cnt_d = cnt_inc;
               if (cnt_inc == DEATH_N) begin
                  state_d = OVER;
                  cnt_d   = '0;
                  ended_d = 1'b1;
                  if (final_q > high_q) begin
                     high_d = final_q;
                     nhs_d  = 1'b1;
                  end
               end
            end
         end
         OVER: begin
            // keyStart has priority over keyCredit once keys are live
            if (keys_ok && bus.keyStart) begin
               rst_g_d = 1'b1;
               ended_d = 1'b0;
               nhs_d   = 1'b0;
               cnt_d   = '0;
               state_d = PLAY;
            end else if (keys_ok && bus.keyCredit) begin
               cred_d  = 1'b1;
               cnt_d   = '0;
               state_d = CREDITS;
            end else if (bus.startOfFrame && !keys_ok) begin
               cnt_d = cnt_inc;
            end
         end
         CREDITS: begin
            if (bus.keyCredit || (bus.startOfFrame && cnt_inc == CRED_N)) begin
               cred_d  = 1'b0;
               cnt_d   = MIN_N;
               state_d = OVER;
            end else if (bus.startOfFrame) begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = PLAY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= PLAY;
         cnt_q   <= '0;
         final_q <= '0;
         high_q  <= '0;
         ended_q <= 1'b0;
         nhs_q   <= 1'b0;
         cred_q  <= 1'b0;
         rst_g_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         final_q <= final_d;
         high_q  <= high_d;
         ended_q <= ended_d;
         nhs_q   <= nhs_d;
         cred_q  <= cred_d;
         rst_g_q <= rst_g_d;
      end
   end

   assign bus.gameEnded     = ended_q;
   assign bus.newHighScore  = nhs_q;
   assign bus.highScore     = high_q;
   assign bus.creditsActive = cred_q;
   assign bus.restartGame   = rst_g_q;
endmodule

// File: tb/tb_end_game_ctrl.sv
// Directed + random bench for end_game_ctrl against a per-cycle game model.
module tb_end_game_ctrl;
   localparam int W     = 16;
   localparam int DEATH = 60;
   localparam int MINF  = 30;
   localparam int CREDF = 300;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   end_game_if #(.SCORE_W(W)) bus ();

   end_game_ctrl #(
      .SCORE_W(W),
      .DEATH_DELAY_FRAMES(DEATH),
      .MIN_END_FRAMES(MINF),
      .CREDIT_FRAMES(CREDF)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int n_chk = 0;
   int n_fail = 0;

   // Model: phase name plus an unbounded count of frames seen in that phase.
   string          m_phase;
   int             m_frames;
   logic [W-1:0]   m_final, m_hi;
   logic           m_ended, m_nhs, m_cred, m_rst;

   task automatic chkb(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic m_clear();
      m_phase = "play";
      m_frames = 0;
      m_final = '0;
      m_hi = '0;
      m_ended = 0;
      m_nhs = 0;
      m_cred = 0;
      m_rst = 0;
   endtask

   task automatic m_step(input bit sof, input bit dead, input bit land,
                         input bit ks, input bit kc, input logic [W-1:0] sc);
      m_rst = 0;
      if (m_phase == "play") begin
         if (dead || land) begin
            m_final = sc;
            m_frames = 0;
            m_phase = "dying";
         end
      end else if (m_phase == "dying") begin
         if (sof) m_frames++;
         if (m_frames == DEATH) begin
            m_phase = "over";
            m_frames = 0;
            m_ended = 1;
            if (m_final > m_hi) begin
               m_hi = m_final;
               m_nhs = 1;
            end
         end
      end else if (m_phase == "over") begin
         if (m_frames >= MINF && ks) begin
            m_rst = 1;
            m_ended = 0;
            m_nhs = 0;
            m_frames = 0;
            m_phase = "play";
         end else if (m_frames >= MINF && kc) begin
            m_cred = 1;
            m_frames = 0;
            m_phase = "credits";
         end else if (sof) begin
            m_frames++;
         end
      end else begin
         if (sof) m_frames++;
         if (kc || m_frames == CREDF) begin
            m_cred = 0;
            m_frames = MINF;
            m_phase = "over";
         end
      end
   endtask

   task automatic check_all(input string where);
      chkb({where, ".gameEnded"}, bus.gameEnded, m_ended);
      chkb({where, ".newHighScore"}, bus.newHighScore, m_nhs);
      chkw({where, ".highScore"}, bus.highScore, m_hi);
      chkb({where, ".creditsActive"}, bus.creditsActive, m_cred);
      chkb({where, ".restartGame"}, bus.restartGame, m_rst);
   endtask

   // One clock: inputs applied at negedge, model stepped at posedge, checked 1 later.
   task automatic cyc(input bit sof, input bit dead, input bit land,
                      input bit ks, input bit kc);
      bus.startOfFrame = sof;
      bus.playerDead = dead;
      bus.invadersLanded = land;
      bus.keyStart = ks;
      bus.keyCredit = kc;
      @(posedge clk);
      m_step(sof, dead, land, ks, kc, bus.score);
      #1;
      check_all("cyc");
      @(negedge clk);
      bus.startOfFrame = 0;
      bus.playerDead = 0;
      bus.invadersLanded = 0;
      bus.keyStart = 0;
      bus.keyCredit = 0;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(1, 0, 0, 0, 0);
         cyc(0, 0, 0, 0, 0);
      end
   endtask

   task automatic end_game(input logic [W-1:0] sc, input bit land);
      bus.score = sc;
      cyc(0, !land, land, 0, 0);
      frames(DEATH);
   endtask

   task automatic do_reset();
      reset = 1;
      #2;
      m_clear();
      chkb("rst.gameEnded", bus.gameEnded, 1'b0);
      chkw("rst.highScore", bus.highScore, '0);
      check_all("rst");
      @(negedge clk);
      @(negedge clk);
      reset = 0;
   endtask

   initial begin
      bus.startOfFrame = 0;
      bus.playerDead = 0;
      bus.invadersLanded = 0;
      bus.keyStart = 0;
      bus.keyCredit = 0;
      bus.score = '0;
      m_clear();
      reset = 1;
      @(negedge clk);
      @(negedge clk);
      reset = 0;
      check_all("por");

      // Prior game loads a high score, then reset wipes it.
      end_game(16'd500, 0);
      chkw("pre.highScore", bus.highScore, 16'd500);
      do_reset();
      cyc(0, 0, 0, 1, 0);
      chkb("rst.noRestart", bus.restartGame, 1'b0);
      cyc(0, 0, 0, 0, 1);
      chkb("rst.noCredits", bus.creditsActive, 1'b0);

      // First game: end screen exactly one cycle after frame 60.
      bus.score = 16'd1200;
      cyc(0, 1, 0, 0, 0);
      bus.score = 16'd5000;
      for (int i = 0; i < DEATH - 1; i++) begin
         cyc(1, 0, 0, 0, 0);
         cyc(0, 0, 0, 0, 0);
      end
      chkb("g1.endedEarly", bus.gameEnded, 1'b0);
      cyc(1, 0, 0, 0, 0);
      chkb("g1.ended", bus.gameEnded, 1'b1);
      chkw("g1.highScore", bus.highScore, 16'd1200);
      chkb("g1.newHigh", bus.newHighScore, 1'b1);

      // Keys ignored before the minimum end-screen time.
      frames(10);
      cyc(0, 0, 0, 1, 0);
      chkb("g1.keyEarly", bus.restartGame, 1'b0);
      frames(MINF - 10);
      cyc(0, 0, 0, 1, 0);
      chkb("g1.restart", bus.restartGame, 1'b1);
      chkb("g1.endedFall", bus.gameEnded, 1'b0);
      cyc(0, 0, 0, 0, 0);
      chkb("g1.restartOnce", bus.restartGame, 1'b0);

      // Equal and lower scores are not a new high.
      end_game(16'd1200, 1);
      chkb("g2.newHigh", bus.newHighScore, 1'b0);
      chkw("g2.highScore", bus.highScore, 16'd1200);
      frames(MINF);
      cyc(0, 0, 0, 1, 0);
      end_game(16'd900, 1);
      chkb("g3.newHigh", bus.newHighScore, 1'b0);
      chkw("g3.highScore", bus.highScore, 16'd1200);

      // Credits view round trip.
      frames(MINF);
      cyc(0, 0, 0, 0, 1);
      chkb("cr.active", bus.creditsActive, 1'b1);
      cyc(0, 0, 0, 1, 0);
      chkb("cr.startIgnored", bus.restartGame, 1'b0);
      frames(CREDF);
      chkb("cr.timeout", bus.creditsActive, 1'b0);
      chkb("cr.stillEnded", bus.gameEnded, 1'b1);
      cyc(0, 0, 0, 1, 0);
      chkb("cr.restart", bus.restartGame, 1'b1);

      // Both keys at once: restart wins.
      end_game(16'd1500, 0);
      chkb("g4.newHigh", bus.newHighScore, 1'b1);
      frames(MINF);
      cyc(0, 0, 0, 1, 1);
      chkb("both.restart", bus.restartGame, 1'b1);
      chkb("both.noCredits", bus.creditsActive, 1'b0);

      // Reset during DYING.
      bus.score = 16'd7;
      cyc(0, 1, 0, 0, 0);
      frames(5);
      do_reset();
      chkw("dyRst.highScore", bus.highScore, '0);

      // Random traffic with sparse keys and occasional resets.
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 2999) == 0) begin
            do_reset();
         end else begin
            bus.score = W'($urandom);
            cyc($urandom_range(0, 1) == 1,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 29) == 0,
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 15) == 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
